// File: rtl/system_pkg.sv
// rtl/system_pkg.sv - command/response constants and state types for the UART LED engine
package system_pkg;

   localparam logic [7:0] CMD_LED           = 8'h4C;
   localparam logic [7:0] CMD_READ          = 8'h52;
   localparam logic [7:0] RSP_OK            = 8'h4B;
   localparam logic [7:0] RSP_ERR           = 8'h3F;
   localparam logic [7:0] BOOT_BYTE_DEFAULT = 8'h42;

   typedef enum logic {
      IDLE,
      WAIT_DATA
   } parser_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/system_uart_lite.sv
// rtl/system_uart_lite.sv - 8N1 UART: TX serializer and synchronized RX deserializer
module uart_lite
   import system_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       uart_tx_o,
   input  logic       uart_rx_i,
   output logic       rx_valid,
   output logic [7:0] rx_data
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic [9:0]    tx_shreg;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_idx;
   logic          tx_line;

   // Asserted during the last cycle of the stop bit.
   assign tx_done   = tx_busy && (tx_cnt == BIT_LAST) && (tx_idx == 4'd9);
   assign uart_tx_o = tx_line;

   always_ff @(posedge clk_in) begin
      if (rst_n) begin
         tx_busy  <= 1'b0;
         tx_line  <= 1'b1;
         tx_shreg <= '1;
         tx_cnt   <= '0;
         tx_idx   <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_line  <= 1'b0;
            tx_shreg <= {1'b1, tx_data, 1'b0};
            tx_cnt   <= '0;
            tx_idx   <= '0;
         end
      end else if (tx_cnt == BIT_LAST) begin
         tx_cnt <= '0;
         if (tx_idx == 4'd9) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
         end else begin
            tx_idx   <= tx_idx + 4'd1;
            tx_shreg <= {1'b1, tx_shreg[9:1]};
            tx_line  <= tx_shreg[1];
         end
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   logic [1:0]    rx_sync;
   logic          rx_s;
   logic          rx_prev;
   rx_state_t     rx_state, rx_state_d;
   logic [CW-1:0] rx_cnt, rx_cnt_d;
   logic [2:0]    rx_idx, rx_idx_d;
   logic [7:0]    rx_shreg, rx_shreg_d;
   logic          rx_valid_d;
   logic [7:0]    rx_data_d;

   assign rx_s = rx_sync[1];

   always_ff @(posedge clk_in) begin
      if (rst_n) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shreg <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], uart_rx_i};
         rx_prev  <= rx_s;
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_idx   <= rx_idx_d;
         rx_shreg <= rx_shreg_d;
         rx_valid <= rx_valid_d;
         rx_data  <= rx_data_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state;
      rx_cnt_d   = rx_cnt;
      rx_idx_d   = rx_idx;
      rx_shreg_d = rx_shreg;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shreg_d = {rx_s, rx_shreg[7:1]};
               rx_idx_d   = rx_idx + 3'd1;
               if (rx_idx == 3'd7) rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_state_d = RX_IDLE;
               if (rx_s) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = rx_shreg;
               end
            end else begin
               rx_cnt_d = rx_cnt + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/system_top.sv
// rtl/system_top.sv - UART command engine driving an LED register; SYSTEM_HEARTBEAT_EN adds a heartbeat on LED 7
module system_top
   import system_pkg::*;
#(
   parameter int         CLKS_PER_BIT     = 868,
   parameter logic [7:0] BOOT_BYTE        = BOOT_BYTE_DEFAULT,
   parameter int         HEARTBEAT_CYCLES = 50_000_000
) (
   input  logic       clk_in,
   input  logic       rst_n,
   output logic [7:0] gpio_leds,
   output logic       uart_tx_o,
   input  logic       uart_rx_i
);

`ifdef SYSTEM_HEARTBEAT_EN
   localparam logic [7:0] CMD_MASK = 8'h7F;
`else
   localparam logic [7:0] CMD_MASK = 8'hFF;
`endif

   parser_state_t state, state_d;
   logic [7:0]    led_q, led_d;
   logic          slot_full, slot_full_d;
   logic [7:0]    slot_data, slot_data_d;
   logic          boot_pending, boot_pending_d;
   logic          boot_active, boot_active_d;
   logic          tx_start, tx_busy, tx_done, rx_valid;
   logic [7:0]    tx_data, rx_data;
   logic          rsp_req;
   logic [7:0]    rsp_byte;

   uart_lite #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .uart_tx_o (uart_tx_o),
      .uart_rx_i (uart_rx_i),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data)
   );

   always_ff @(posedge clk_in) begin
      if (rst_n) begin
         state        <= IDLE;
         led_q        <= 8'h00;
         slot_full    <= 1'b0;
         slot_data    <= 8'h00;
         boot_pending <= 1'b1;
         boot_active  <= 1'b0;
      end else begin
         state        <= state_d;
         led_q        <= led_d;
         slot_full    <= slot_full_d;
         slot_data    <= slot_data_d;
         boot_pending <= boot_pending_d;
         boot_active  <= boot_active_d;
      end
   end

   always_comb begin
      state_d        = state;
      led_d          = led_q;
      slot_full_d    = slot_full;
      slot_data_d    = slot_data;
      boot_pending_d = boot_pending;
      boot_active_d  = boot_active;
      tx_start       = 1'b0;
      tx_data        = BOOT_BYTE;
      rsp_req        = 1'b0;
      rsp_byte       = RSP_ERR;

      // The boot byte wins the first TX slot; the response slot drains afterwards.
      if (!tx_busy) begin
         if (boot_pending) begin
            tx_start       = 1'b1;
            boot_pending_d = 1'b0;
            boot_active_d  = 1'b1;
         end else if (slot_full) begin
            tx_start    = 1'b1;
            tx_data     = slot_data;
            slot_full_d = 1'b0;
         end
      end

      if (tx_done && boot_active) begin
         boot_active_d = 1'b0;
         led_d         = (led_q & ~CMD_MASK) | (8'h01 & CMD_MASK);
      end

      if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == CMD_LED) begin
                  state_d = WAIT_DATA;
               end else if (rx_data == CMD_READ) begin
                  rsp_req  = 1'b1;
                  rsp_byte = gpio_leds;
               end else begin
                  rsp_req  = 1'b1;
                  rsp_byte = RSP_ERR;
               end
            end
            WAIT_DATA: begin
               led_d    = (led_q & ~CMD_MASK) | (rx_data & CMD_MASK);
               rsp_req  = 1'b1;
               rsp_byte = RSP_OK;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // A response that finds the slot still occupied is dropped.
      if (rsp_req && !slot_full_d) begin
         slot_full_d = 1'b1;
         slot_data_d = rsp_byte;
      end
   end

`ifdef SYSTEM_HEARTBEAT_EN
   localparam int HB_W = $clog2(HEARTBEAT_CYCLES);
   logic [HB_W-1:0] hb_cnt;
   logic            hb_q;

   always_ff @(posedge clk_in) begin
      if (rst_n) begin
         hb_cnt <= '0;
         hb_q   <= 1'b0;
      end else if (hb_cnt == HB_W'(HEARTBEAT_CYCLES - 1)) begin
         hb_cnt <= '0;
         hb_q   <= ~hb_q;
      end else begin
         hb_cnt <= hb_cnt + 1'b1;
      end
   end

   assign gpio_leds = led_q | {hb_q, 7'b0};
`else
   assign gpio_leds = led_q;
`endif

endmodule

// File: tb/tb_system_top.sv
// tb/tb_system_top.sv - directed vector bench for system_top at 8 clocks per UART bit
module tb_system_top;
   import system_pkg::*;

   localparam int CPB = 8;
`ifdef SYSTEM_HEARTBEAT_EN
   localparam logic [7:0] LM = 8'h7F;
`else
   localparam logic [7:0] LM = 8'hFF;
`endif

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic [7:0] gpio_leds;
   logic       uart_tx_o;
   logic       uart_rx_i;

   int checks = 0;
   int fails  = 0;
   logic [7:0] tx_q[$];

   system_top #(.CLKS_PER_BIT(CPB), .BOOT_BYTE(8'h42), .HEARTBEAT_CYCLES(20)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .gpio_leds (gpio_leds),
      .uart_tx_o (uart_tx_o),
      .uart_rx_i (uart_rx_i)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] cmd;
      logic       has_data;
      logic [7:0] data;
      logic [7:0] rsp;
      logic [7:0] leds;
   } vec_t;
   vec_t vecs[9];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx_i = 1'b0;
      repeat (CPB) @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = b[i];
         repeat (CPB) @(negedge clk_in);
      end
      uart_rx_i = stop;
      repeat (CPB) @(negedge clk_in);
      uart_rx_i = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic expect_rsp(input string name, input logic [7:0] exp);
      int t = 0;
      while (tx_q.size() == 0 && t < 400) begin
         @(negedge clk_in);
         t++;
      end
      if (tx_q.size() == 0) begin
         checks++;
         fails++;
         $display("FAIL %s: no TX byte within 400 cycles, expected %02h", name, exp);
      end else begin
         check(name, tx_q.pop_front() & LM, exp & LM);
      end
   endtask

   task automatic expect_none(input string name);
      repeat (200) @(negedge clk_in);
      check(name, 8'(tx_q.size()), 8'h00);
   endtask

   // TX line decoder; samples mid-bit on falling clock edges and abandons a frame cut by reset.
   initial begin
      logic       prev;
      logic       abort;
      logic [7:0] b;
      prev = 1'b1;
      b    = 8'h00;
      forever begin
         @(negedge clk_in);
         if (!rst_n && prev && !uart_tx_o) begin
            abort = 1'b0;
            for (int k = 0; k < 75 && !abort; k++) begin
               @(negedge clk_in);
               if (rst_n) abort = 1'b1;
               else if (k >= 10 && k < 74 && ((k - 2) % 8) == 0) b[(k - 2) / 8 - 1] = uart_tx_o;
               else if (k == 74) begin
                  check("tx_stop_bit", {7'b0, uart_tx_o}, 8'h01);
                  tx_q.push_back(b);
               end
            end
         end
         prev = uart_tx_o;
      end
   end

   initial begin
      int t;
      vecs[0] = '{CMD_READ, 1'b0, 8'h00, 8'hA5, 8'hA5};
      vecs[1] = '{8'h00,    1'b0, 8'h00, RSP_ERR, 8'hA5};
      vecs[2] = '{8'h4B,    1'b0, 8'h00, RSP_ERR, 8'hA5};
      vecs[3] = '{CMD_LED,  1'b1, 8'h4C, RSP_OK, 8'h4C};
      vecs[4] = '{CMD_READ, 1'b0, 8'h00, 8'h4C, 8'h4C};
      vecs[5] = '{CMD_LED,  1'b1, 8'h00, RSP_OK, 8'h00};
      vecs[6] = '{CMD_READ, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[7] = '{CMD_LED,  1'b1, 8'h5A, RSP_OK, 8'h5A};
      vecs[8] = '{CMD_READ, 1'b0, 8'h00, 8'h5A, 8'h5A};

      uart_rx_i = 1'b1;
      rst_n     = 1'b1;
      repeat (10) @(negedge clk_in);
      check("reset_leds", gpio_leds, 8'h00);
      check("reset_tx", {7'b0, uart_tx_o}, 8'h01);

      rst_n = 1'b0;
      check("release_tx_idle", {7'b0, uart_tx_o}, 8'h01);
      @(negedge clk_in);
      check("boot_start_bit", {7'b0, uart_tx_o}, 8'h00);
      repeat (78) @(negedge clk_in);
      check("boot_leds_before_stop_end", gpio_leds & LM, 8'h00);
      check("boot_stop_high", {7'b0, uart_tx_o}, 8'h01);
      repeat (2) @(negedge clk_in);
      check("boot_leds_after", gpio_leds & LM, 8'h01);
      expect_rsp("boot_byte", 8'h42);

      send_byte(CMD_LED, 1'b1);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            t = 0;
            while (!dut.u_uart.rx_valid && t < 200) begin
               @(negedge clk_in);
               t++;
            end
            if (!dut.u_uart.rx_valid) begin
               checks++;
               fails++;
               $display("FAIL led_write_rx_valid: no rx_valid within 200 cycles");
            end else begin
               check("led_write_same_cycle", gpio_leds & LM, 8'h01);
               @(negedge clk_in);
               check("led_write_next_cycle", gpio_leds & LM, 8'hA5 & LM);
            end
         end
      join
      expect_rsp("led_write_rsp", RSP_OK);

      for (int i = 0; i < 9; i++) begin
         send_byte(vecs[i].cmd, 1'b1);
         if (vecs[i].has_data) send_byte(vecs[i].data, 1'b1);
         expect_rsp($sformatf("vec%0d_rsp", i), vecs[i].rsp);
         check($sformatf("vec%0d_leds", i), gpio_leds & LM, vecs[i].leds & LM);
      end

      send_byte(CMD_LED, 1'b0);
      expect_none("framing_no_rsp");
      send_byte(CMD_READ, 1'b1);
      expect_rsp("framing_parser_idle", 8'h5A);

      uart_rx_i = 1'b0;
      repeat (2) @(negedge clk_in);
      uart_rx_i = 1'b1;
      expect_none("glitch_no_rsp");
      send_byte(CMD_READ, 1'b1);
      expect_rsp("glitch_then_read", 8'h5A);

      send_byte(CMD_READ, 1'b1);
      t = 0;
      while (uart_tx_o && t < 200) begin
         @(negedge clk_in);
         t++;
      end
      check("midframe_tx_started", {7'b0, uart_tx_o}, 8'h00);
      repeat (20) @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
      check("midframe_reset_tx", {7'b0, uart_tx_o}, 8'h01);
      check("midframe_reset_leds", gpio_leds, 8'h00);
      repeat (3) @(negedge clk_in);
      rst_n = 1'b0;
      @(negedge clk_in);
      check("reboot_start_bit", {7'b0, uart_tx_o}, 8'h00);
      expect_rsp("reboot_byte", 8'h42);
      repeat (10) @(negedge clk_in);
      check("reboot_leds", gpio_leds & LM, 8'h01);
      check("reboot_queue_empty", 8'(tx_q.size()), 8'h00);

`ifdef SYSTEM_HEARTBEAT_EN
      begin
         logic hb;
         hb = gpio_leds[7];
         t  = 0;
         while (gpio_leds[7] == hb && t < 50) begin
            @(negedge clk_in);
            t++;
         end
         hb = gpio_leds[7];
         repeat (19) @(negedge clk_in);
         check("hb_hold", {7'b0, gpio_leds[7]}, {7'b0, hb});
         @(negedge clk_in);
         check("hb_toggle", {7'b0, gpio_leds[7]}, {7'b0, ~hb});
         send_byte(CMD_LED, 1'b1);
         send_byte(8'hFF, 1'b1);
         expect_rsp("hb_write_rsp", RSP_OK);
         check("hb_write_low_bits", gpio_leds & 8'h7F, 8'h7F);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
